// File: rtl/spi_reg_pkg.sv
// Shared constants, register-file layout and FSM encoding for the SPI register bank.
// No logic here; latency and backpressure are properties of the users.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned NUM_REGS   = 5;
  localparam int unsigned CNT_MAX    = FRAME_BITS + 1;

  localparam logic [6:0] ADDR_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY   = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } spi_state_t;

  typedef struct packed {
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
  } regfile_t;

  // Unmapped addresses read back as register 0x00.
  function automatic logic [7:0] reg_read(input regfile_t rf, input logic [6:0] addr);
    case (addr)
      ADDR_OUT_HI: reg_read = rf.en_reg_out_15_8;
      ADDR_PWM_LO: reg_read = rf.en_reg_pwm_7_0;
      ADDR_PWM_HI: reg_read = rf.en_reg_pwm_15_8;
      ADDR_DUTY:   reg_read = rf.pwm_duty_cycle;
      default:     reg_read = rf.en_reg_out_7_0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous pin into clk; 2 cycles latency.
// No backpressure; resets low so a pin held low at reset release produces no edge.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave writing a 5-byte register file; updates land one cycle after detected ncs rise.
// No backpressure (host paced); optional readback on cipo when SPI_READBACK_EN is defined.
module spi_reg_bank
  import spi_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  logic sclk_s, copi_s, ncs_s;
  logic sclk_q, ncs_q;

  sync_2ff u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  sync_2ff u_sync_copi (.clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));
  sync_2ff u_sync_ncs  (.clk(clk), .rst_n(rst_n), .d(ncs),  .q(ncs_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      ncs_q  <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      ncs_q  <= ncs_s;
    end
  end

  logic sclk_rise, sclk_fall, ncs_fall, ncs_rise;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ncs_fall  = ncs_q & ~ncs_s;
  assign ncs_rise  = ~ncs_q & ncs_s;

  spi_state_t  state;
  logic [15:0] shreg;
  logic [4:0]  cnt;
  regfile_t    regs;

  logic       frm_wr;
  logic [6:0] frm_addr;
  logic [7:0] frm_dat;
  assign frm_wr   = shreg[15];
  assign frm_addr = shreg[14:8];
  assign frm_dat  = shreg[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      regs      <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ncs_fall) begin
            state <= ST_SHIFT;
            shreg <= '0;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          // ncs rise wins over a coincident sclk rise; that edge is dropped.
          if (ncs_rise) begin
            state <= ST_COMMIT;
          end else if (sclk_rise) begin
            shreg <= {shreg[14:0], copi_s};
            if (cnt != 5'(CNT_MAX)) cnt <= cnt + 5'd1;
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          if (cnt == 5'(FRAME_BITS)) begin
            if (frm_wr && (frm_addr < 7'(NUM_REGS))) begin
              wr_strobe <= 1'b1;
              case (frm_addr)
                ADDR_OUT_LO: regs.en_reg_out_7_0  <= frm_dat;
                ADDR_OUT_HI: regs.en_reg_out_15_8 <= frm_dat;
                ADDR_PWM_LO: regs.en_reg_pwm_7_0  <= frm_dat;
                ADDR_PWM_HI: regs.en_reg_pwm_15_8 <= frm_dat;
                default:     regs.pwm_duty_cycle  <= frm_dat;
              endcase
            end
          end else if (cnt != 5'd0) begin
            frame_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs.en_reg_out_7_0;
  assign en_reg_out_15_8 = regs.en_reg_out_15_8;
  assign en_reg_pwm_7_0  = regs.en_reg_pwm_7_0;
  assign en_reg_pwm_15_8 = regs.en_reg_pwm_15_8;
  assign pwm_duty_cycle  = regs.pwm_duty_cycle;

`ifdef SPI_READBACK_EN
  logic [7:0] tx_sh;
  logic       shift_go;
  assign shift_go = (state == ST_SHIFT) && !ncs_rise;

  // shreg holds 7 bits before the 8th rise: [6] is R/W, [5:0] plus copi_s form the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh   <= '0;
      cipo    <= 1'b0;
      cipo_oe <= 1'b0;
    end else begin
      cipo_oe <= (state == ST_SHIFT) || (state == ST_IDLE && ncs_fall);
      if (state != ST_SHIFT) begin
        cipo <= 1'b0;
      end else if (shift_go && sclk_rise && cnt == 5'd7) begin
        tx_sh <= shreg[6] ? 8'h00 : reg_read(regs, {shreg[5:0], copi_s});
      end else if (shift_go && sclk_fall && cnt >= 5'd9 && cnt <= 5'd16) begin
        cipo  <= tx_sh[7];
        tx_sh <= {tx_sh[6:0], 1'b0};
      end
    end
  end
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: writes, bad frames, mid-frame reset, readback (SPI_READBACK_EN).
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       cipo, cipo_oe;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_strobe = 0;
  int n_ferr = 0;
  logic [7:0] rx_byte;
  logic       oe_seen;

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) n_strobe++;
    if (frame_err === 1'b1) n_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [39:0] exp);
    check({tag, ".out_lo"}, {24'h0, en_reg_out_7_0},  {24'h0, exp[39:32]});
    check({tag, ".out_hi"}, {24'h0, en_reg_out_15_8}, {24'h0, exp[31:24]});
    check({tag, ".pwm_lo"}, {24'h0, en_reg_pwm_7_0},  {24'h0, exp[23:16]});
    check({tag, ".pwm_hi"}, {24'h0, en_reg_pwm_15_8}, {24'h0, exp[15:8]});
    check({tag, ".duty"},   {24'h0, pwm_duty_cycle},  {24'h0, exp[7:0]});
  endtask

  // Sends bits n-1..0 of d; cipo is sampled late in each low phase, after falls 9..16.
  task automatic spi_bits(input logic [31:0] d, input int n);
    rx_byte = 8'h00;
    oe_seen = 1'b0;
    for (int j = 0; j < n; j++) begin
      copi = d[n-1-j];
      #39;
      if (j >= 9 && j <= 16) rx_byte = {rx_byte[6:0], cipo};
      if (j == 4) oe_seen = cipo_oe;
      #1 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
    #39;
    if (n >= 9 && n <= 16) rx_byte = {rx_byte[6:0], cipo};
    #1;
  endtask

  task automatic spi_frame(input logic [31:0] d, input int n);
    ncs = 1'b0;
    #100;
    spi_bits(d, n);
    ncs = 1'b1;
    #300;
  endtask

  int s0, e0;

  initial begin
    #23;
    check_regs("reset", 40'h0);
    check("reset.wr_strobe", {31'h0, wr_strobe}, 32'h0);
    check("reset.frame_err", {31'h0, frame_err}, 32'h0);
    check("reset.cipo", {31'h0, cipo}, 32'h0);
    check("reset.cipo_oe", {31'h0, cipo_oe}, 32'h0);
    rst_n = 1'b1;
    #100;

    s0 = n_strobe; e0 = n_ferr;
    spi_frame(32'h8455, 16);
    check_regs("wr_duty", 40'h00_00_00_00_55);
    check("wr_duty.strobes", n_strobe - s0, 1);
    check("wr_duty.errs", n_ferr - e0, 0);

    s0 = n_strobe;
    spi_frame(32'h80F0, 16);
    spi_frame(32'h81A5, 16);
    spi_frame(32'h8203, 16);
    spi_frame(32'h833C, 16);
    check_regs("wr_four", 40'hF0_A5_03_3C_55);
    check("wr_four.strobes", n_strobe - s0, 4);

    s0 = n_strobe; e0 = n_ferr;
    spi_frame(32'h8A11, 16);
    check_regs("wr_badaddr", 40'hF0_A5_03_3C_55);
    check("wr_badaddr.strobes", n_strobe - s0, 0);
    check("wr_badaddr.errs", n_ferr - e0, 0);

    s0 = n_strobe; e0 = n_ferr;
    spi_frame(32'h845, 12);
    check("short.errs", n_ferr - e0, 1);
    e0 = n_ferr;
    spi_frame(32'h10855, 17);
    check("long.errs", n_ferr - e0, 1);
    e0 = n_ferr;
    spi_frame(32'h0, 0);
    check("empty.errs", n_ferr - e0, 0);
    check("bad_frames.strobes", n_strobe - s0, 0);
    check_regs("bad_frames", 40'hF0_A5_03_3C_55);

    // Reset with ncs still low and 9 bits shifted; release while ncs stays low.
    e0 = n_ferr; s0 = n_strobe;
    ncs = 1'b0;
    #100;
    spi_bits(32'h84FF >> 7, 9);
    rst_n = 1'b0;
    #3;
    check_regs("midrst", 40'h0);
    check("midrst.cipo", {31'h0, cipo}, 32'h0);
    check("midrst.cipo_oe", {31'h0, cipo_oe}, 32'h0);
    #40 rst_n = 1'b1;
    #100 ncs = 1'b1;
    #300;
    check("midrst.errs", n_ferr - e0, 0);
    check("midrst.strobes", n_strobe - s0, 0);
    spi_frame(32'h8407, 16);
    check_regs("after_rst", 40'h00_00_00_00_07);

    s0 = n_strobe; e0 = n_ferr;
    spi_frame(32'h8266, 16);
    spi_frame(32'h0200, 16);
    check("read.strobes", n_strobe - s0, 1);
    check("read.errs", n_ferr - e0, 0);
    check_regs("read", 40'h00_00_66_00_07);
`ifdef SPI_READBACK_EN
    check("read.cipo_byte", {24'h0, rx_byte}, 32'h66);
    check("read.cipo_oe", {31'h0, oe_seen}, 32'h1);
`else
    check("read.cipo_byte", {24'h0, rx_byte}, 32'h0);
    check("read.cipo_oe", {31'h0, oe_seen}, 32'h0);
`endif
    check("idle.cipo_oe", {31'h0, cipo_oe}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 clk  input  1  system clock; sole clock domain; at least 4x SCLK frequency.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 sclk  input  1  SPI clock from host pin, asynchronous to clk; mode 0.
REQ-005 copi  input  1  SPI data in, MSB first.
REQ-006 ncs  input  1  SPI chip select, active low.
REQ-007 cipo  output  1  SPI data out.
REQ-008 cipo_oe  output  1  pad enable for cipo.
REQ-009 en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  output  8 each  register file, addresses 0x00..0x04; these feed the PWM stage.
REQ-010 wr_strobe  output  1  one-cycle pulse on each committed write.
REQ-011 frame_err  output  1  one-cycle pulse on each malformed frame.

Function
REQ-012 SHALL pass sclk, copi and ncs through two-flop synchronisers; all logic uses the synchronised copies only.
REQ-013 SHALL treat synchronised sclk 0->1 between consecutive clk cycles as a rise and 1->0 as a fall.
REQ-014 SHALL implement FSM IDLE -> SHIFT on synchronised ncs fall; SHIFT -> COMMIT on synchronised ncs rise; COMMIT -> IDLE after exactly one cycle.
REQ-015 On entering SHIFT, the 16-bit shift register and 5-bit bit counter SHALL clear.
REQ-016 Each rise in SHIFT SHALL shift copi in at the LSB; the counter saturates at 17.
REQ-017 Frame format SHALL be bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-018 In COMMIT with count==16, write, address<=0x04: addressed register SHALL take data; wr_strobe high that cycle.
REQ-019 Write with count==16 and address>0x04 SHALL change nothing and pulse neither output.
REQ-020 count==0 SHALL be silently ignored; count in 1..15 or 17 SHALL pulse frame_err and change no register.
REQ-021 Register outputs and wr_strobe SHALL update on the clk edge that enters IDLE from COMMIT, exactly one cycle after synchronised ncs rise.
REQ-022 An ncs rise and sclk rise in the same cycle SHALL resolve as ncs rise; that sclk edge is not counted.

Reset
REQ-023 rst_n low SHALL immediately force IDLE and clear the shift register, counter, all five registers, wr_strobe, frame_err, cipo and cipo_oe.
REQ-024 Reset mid-frame SHALL abandon the frame; the next frame needs a fresh ncs fall after reset release.

Configuration
REQ-025 Macro SPI_READBACK_EN defined: a read frame (bit15=0) SHALL load the addressed register (0x00 for address>0x04) into a tx shift register after the 8th rise and drive its MSB-first bits on cipo, one per sclk fall, for the next 8 falls; cipo_oe is high in SHIFT.
REQ-026 SPI_READBACK_EN undefined: cipo and cipo_oe SHALL be constant 0; read frames with count==16 are ignored with no pulse.

Structure
REQ-027 Package spi_reg_pkg SHALL hold FRAME_BITS=16, NUM_REGS=5, the five address constants, and the FSM state enum.
REQ-028 The two-flop synchroniser SHALL be one sub-module, sync_2ff, instantiated three times.

Verification
REQ-029 Write frame 0x8455 -> pwm_duty_cycle=0x55 and one wr_strobe pulse, one cycle after synchronised ncs rise; other registers unchanged.
REQ-030 Write 0x80F0, 0x81A5, 0x8203, 0x833C -> registers 0xF0, 0xA5, 0x03, 0x3C; four strobes.
REQ-031 Write 0x8A11 (address 0x0A) -> no register change; no wr_strobe; no frame_err.
REQ-032 12-bit frame, 17-bit frame, and ncs pulse with no sclk -> frame_err pulses, pulses, none; registers unchanged.
REQ-033 rst_n low after 9 bits of 0x84FF -> all outputs 0; next full frame 0x8407 -> pwm_duty_cycle=0x07.
REQ-034 SPI_READBACK_EN: write 0x8266, then read 0x0200 -> cipo shifts 0x66 on falls 9..16, cipo_oe high during frame.
